// File: rtl/alg_sequencer.sv
// alg_sequencer: run-control sequencer in front of alg_core.
// Paces ADC requests from a clock divider and registers accepted samples into the core.
// Drives the core clock-enable and sample counter, and tracks warm-up.
// Buffers RR periods in a show-ahead FIFO with a valid/ready read port.
// Optional feature: define ALG_SEQ_WATCHDOG_EN to build the sample watchdog behind o_timeout.
module alg_sequencer #(
  parameter int DATA_WIDTH      = 11,
  parameter int CTR_WIDTH       = 22,
  parameter int DIV_WIDTH       = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_SAMPLES = 1000
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic [DIV_WIDTH-1:0]         i_div,
  output logic                         o_sample_req,
  input  logic signed [DATA_WIDTH-1:0] i_adc_sample,
  input  logic                         i_adc_valid,
  output logic signed [DATA_WIDTH-1:0] o_ecg_signal,
  output logic                         o_ecg_signal_valid,
  output logic                         o_ce,
  output logic [CTR_WIDTH-1:0]         o_ctr,
  input  logic                         i_ma_long_valid,
  input  logic                         i_th_initialised,
  input  logic [CTR_WIDTH-1:0]         i_rr_period,
  input  logic                         i_rr_period_updated,
  output logic [CTR_WIDTH-1:0]         o_rr_data,
  output logic                         o_rr_valid,
  input  logic                         i_rr_ready,
  output logic [1:0]                   o_state,
  output logic                         o_overflow,
  output logic                         o_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WARMUP = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

  state_t                       state, state_nxt;
  logic                         active;
  logic                         start_go;
  logic [DIV_WIDTH-1:0]         div_cnt, div_lat;
  logic signed [DATA_WIDTH-1:0] ecg_p1;
  logic                         vld_p1;
  logic [CTR_WIDTH-1:0]         ctr;
  logic [CTR_WIDTH-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             count;
  logic                         overflow;
  logic                         fifo_full, fifo_nonempty;
  logic                         push_req, push, pop;

  assign start_go      = (state == IDLE) && i_start;
  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
  assign push_req      = (state == RUN) && i_rr_period_updated;
  assign pop           = fifo_nonempty && i_rr_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push          = push_req && (!fifo_full || pop);

  // State register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; stop outranks the warm-up exit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = WARMUP;
      WARMUP:  if (i_stop) state_nxt = DRAIN;
               else if (i_ma_long_valid && i_th_initialised) state_nxt = RUN;
      RUN:     if (i_stop) state_nxt = DRAIN;
      DRAIN:   if (!fifo_nonempty || (count == CNT_W'(1) && pop)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register and divider count
  always_comb begin
    active       = (state == WARMUP) || (state == RUN);
    o_ce         = active;
    o_sample_req = active && (div_cnt == div_lat);
  end

  // Sample-period divider: counts 0..div_lat while active, parked at 0 otherwise
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else begin
      if (start_go) div_lat <= i_div;
      if (!active || div_cnt == div_lat) div_cnt <= '0;
      else                               div_cnt <= div_cnt + 1'b1;
    end
  end

  // Stage p1: register accepted ADC samples and count them
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ecg_p1 <= '0;
      vld_p1 <= 1'b0;
      ctr    <= '0;
    end else begin
      vld_p1 <= active && i_adc_valid;
      if (active && i_adc_valid) ecg_p1 <= i_adc_sample;
      if (start_go)                   ctr <= '0;
      else if (active && i_adc_valid) ctr <= ctr + 1'b1;
    end
  end

  assign o_ecg_signal       = ecg_p1;
  assign o_ecg_signal_valid = vld_p1;
  assign o_ctr              = ctr;

  // RR FIFO control: pointers, occupancy and sticky overflow
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (start_go) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // RR FIFO storage; contents need no reset because occupancy gates the output
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_rr_period;
  end

  assign o_rr_valid = fifo_nonempty;
  assign o_rr_data  = fifo_nonempty ? mem[rd_ptr] : '0;
  assign o_overflow = overflow;
  assign o_state    = state;

`ifdef ALG_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_SAMPLES);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout;

  // Watchdog: accepted samples in RUN since the last RR update, saturating at the limit
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (start_go) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state == RUN) begin
      if (i_rr_period_updated) begin
        wd_cnt <= '0;
      end else if (i_adc_valid && wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_LIMIT - 1'b1) timeout <= 1'b1;
      end
    end
  end

  assign o_timeout = timeout;
`else
  // watchdog not built: the flag is a constant low
  localparam logic WD_TIE = (TIMEOUT_SAMPLES < 0);
  assign o_timeout = WD_TIE;
`endif

endmodule
